// File: rtl/uart_hex_tx.sv
// uart_hex_tx: prints WIDTH-bit words as ASCII hex (MS nibble first) plus a separator into a byte stream.
// Define UART_HEX_TX_CRLF_EN for a CR LF separator; otherwise a single space (0x20) ends each word.
module uart_hex_tx #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned UPPER = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             word_ready,
    input  logic             word_valid,
    input  logic [WIDTH-1:0] word_data,
    input  logic             data_ready,
    output logic             data_valid,
    output logic [7:0]       data_byte
);
    localparam int unsigned NDIG = WIDTH / 4;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
`ifdef UART_HEX_TX_CRLF_EN
    localparam logic [7:0] SEP_BYTE = 8'h0D;
`else
    localparam logic [7:0] SEP_BYTE = 8'h20;
`endif

    typedef enum logic [1:0] {
        IDLE,
        DIGIT,
`ifdef UART_HEX_TX_CRLF_EN
        LF,
`endif
        SEP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             word_ready_q, word_ready_d;
    logic             data_valid_q, data_valid_d;
    logic [7:0]       data_byte_q, data_byte_d;
    logic [WIDTH-1:0] shreg_next;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] base;
        base = (UPPER != 0) ? 8'h41 : 8'h61;
        if (nib < 4'd10) begin
            return 8'h30 + 8'(nib);
        end
        return base + 8'(nib) - 8'd10;
    endfunction

    assign shreg_next = shreg_q << 4;

    // Outputs are computed for the next cycle so every port comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        word_ready_d = word_ready_q;
        data_valid_d = data_valid_q;
        data_byte_d  = data_byte_q;
        case (state_q)
            IDLE: begin
                word_ready_d = 1'b1;
                data_valid_d = 1'b0;
                if (word_valid && word_ready_q) begin
                    shreg_d      = word_data;
                    cnt_d        = CW'(NDIG - 1);
                    data_byte_d  = hex_char(word_data[WIDTH-1 -: 4]);
                    data_valid_d = 1'b1;
                    word_ready_d = 1'b0;
                    state_d      = DIGIT;
                end
            end
            DIGIT: begin
                if (data_ready) begin
                    if (cnt_q != '0) begin
                        shreg_d     = shreg_next;
                        cnt_d       = cnt_q - CW'(1);
                        data_byte_d = hex_char(shreg_next[WIDTH-1 -: 4]);
                    end else begin
                        data_byte_d = SEP_BYTE;
                        state_d     = SEP;
                    end
                end
            end
            SEP: begin
                if (data_ready) begin
`ifdef UART_HEX_TX_CRLF_EN
                    data_byte_d  = 8'h0A;
                    state_d      = LF;
`else
                    data_valid_d = 1'b0;
                    word_ready_d = 1'b1;
                    state_d      = IDLE;
`endif
                end
            end
`ifdef UART_HEX_TX_CRLF_EN
            LF: begin
                if (data_ready) begin
                    data_valid_d = 1'b0;
                    word_ready_d = 1'b1;
                    state_d      = IDLE;
                end
            end
`endif
            default: begin
                data_valid_d = 1'b0;
                word_ready_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // Reset drops any partial line without emitting a separator.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            word_ready_q <= 1'b0;
            data_valid_q <= 1'b0;
            data_byte_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            word_ready_q <= word_ready_d;
            data_valid_q <= data_valid_d;
            data_byte_q  <= data_byte_d;
        end
    end

    assign word_ready = word_ready_q;
    assign data_valid = data_valid_q;
    assign data_byte  = data_byte_q;

endmodule

// File: tb/tb_uart_hex_tx.sv
// tb_uart_hex_tx: directed and random checks of uart_hex_tx against a string-building hex print model.
// Three instances: 32-bit upper-case, 32-bit lower-case, 8-bit upper-case.
module tb_uart_hex_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        data_ready;
    logic [2:0]  wv;
    logic [2:0]  wr;
    logic [2:0]  dv;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [7:0]  wd2;
    logic [7:0]  db0;
    logic [7:0]  db1;
    logic [7:0]  db2;
    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];

    uart_hex_tx #(.WIDTH(32), .UPPER(1)) u_up (
        .clk(clk), .reset(reset), .word_ready(wr[0]), .word_valid(wv[0]), .word_data(wd0),
        .data_ready(data_ready), .data_valid(dv[0]), .data_byte(db0));
    uart_hex_tx #(.WIDTH(32), .UPPER(0)) u_lo (
        .clk(clk), .reset(reset), .word_ready(wr[1]), .word_valid(wv[1]), .word_data(wd1),
        .data_ready(data_ready), .data_valid(dv[1]), .data_byte(db1));
    uart_hex_tx #(.WIDTH(8), .UPPER(1)) u_w8 (
        .clk(clk), .reset(reset), .word_ready(wr[2]), .word_valid(wv[2]), .word_data(wd2),
        .data_ready(data_ready), .data_valid(dv[2]), .data_byte(db2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] cur_db(input int sel);
        case (sel)
            0:       return db0;
            1:       return db1;
            default: return db2;
        endcase
    endfunction

    task automatic set_word(input int sel, input logic v, input logic [31:0] w);
        case (sel)
            0:       begin wv[0] = v; wd0 = w; end
            1:       begin wv[1] = v; wd1 = w; end
            default: begin wv[2] = v; wd2 = w[7:0]; end
        endcase
    endtask

    // Expected text for one word: hex digits MS first, then the separator.
    function automatic void build_exp(input int sel, input logic [31:0] w);
        int ndig;
        int nib;
        bit up;
        ndig = (sel == 2) ? 2 : 8;
        up   = (sel != 1);
        exp_q.delete();
        for (int i = ndig - 1; i >= 0; i--) begin
            nib = int'((w >> (4 * i)) & 32'hF);
            if (nib < 10) exp_q.push_back(8'(48 + nib));
            else          exp_q.push_back(8'((up ? 65 : 97) + nib - 10));
        end
`ifdef UART_HEX_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`else
        exp_q.push_back(8'h20);
`endif
    endfunction

    task automatic run_line(input int sel, input logic [31:0] w, input bit hold, input logic [31:0] next_w,
                            input int stall_at, input int stall_len, input bit rnd, input int abort_at,
                            output int waited);
        int idx;
        int cyc;
        int n;
        int stalled;
        bit dr;
        build_exp(sel, w);
        n = exp_q.size();
        set_word(sel, 1'b1, w);
        waited = 0;
        while (wr[sel] !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("word_accept", 32'(wr[sel]), 32'd1);
        if (wr[sel] !== 1'b1) begin
            set_word(sel, 1'b0, w);
            return;
        end
        @(negedge clk);
        if (hold) set_word(sel, 1'b1, next_w);
        else      set_word(sel, 1'b0, w);
        idx = 0;
        cyc = 0;
        stalled = 0;
        while (idx < n && idx != abort_at && cyc < 500) begin
            chk("data_valid", 32'(dv[sel]), 32'd1);
            chk("data_byte", 32'(cur_db(sel)), 32'(exp_q[idx]));
            chk("word_ready_busy", 32'(wr[sel]), 32'd0);
            if (rnd) dr = 1'($urandom_range(0, 1));
            else if (idx == stall_at && stalled < stall_len) begin
                dr = 1'b0;
                stalled++;
            end else dr = 1'b1;
            data_ready = dr;
            @(negedge clk);
            if (dr) idx++;
            cyc++;
        end
        data_ready = 1'b1;
        if (abort_at >= 0) return;
        chk("line_done", 32'(idx), 32'(n));
        if (!rnd) chk("line_cycles", 32'(cyc), 32'(n + stall_len));
        chk("data_valid_end", 32'(dv[sel]), 32'd0);
        chk("word_ready_end", 32'(wr[sel]), 32'd1);
    endtask

    initial begin
        int w8;
        reset = 1'b1;
        data_ready = 1'b1;
        wv = 3'b000;
        wd0 = '0;
        wd1 = '0;
        wd2 = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk("rst_data_valid", 32'(dv[s]), 32'd0);
            chk("rst_data_byte", 32'(cur_db(s)), 32'd0);
            chk("rst_word_ready", 32'(wr[s]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_word_ready", 32'(wr), 32'h7);

        run_line(0, 32'hDEADBEEF, 1'b0, 32'h0, -1, 0, 1'b0, -1, w8);
        run_line(1, 32'h00C0FFEE, 1'b0, 32'h0, -1, 0, 1'b0, -1, w8);
        run_line(0, 32'h12345678, 1'b0, 32'h0, 2, 5, 1'b0, -1, w8);

        run_line(0, 32'h00000001, 1'b1, 32'hFFFFFFFF, -1, 0, 1'b0, -1, w8);
        run_line(0, 32'hFFFFFFFF, 1'b0, 32'h0, -1, 0, 1'b0, -1, w8);
        chk("b2b_accept_wait", 32'(w8), 32'd0);

        run_line(0, 32'hA5A5A5A5, 1'b0, 32'h0, -1, 0, 1'b0, 3, w8);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_data_valid", 32'(dv[0]), 32'd0);
        chk("midrst_data_byte", 32'(db0), 32'd0);
        chk("midrst_word_ready", 32'(wr[0]), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_word_ready_up", 32'(wr[0]), 32'd1);
        for (int i = 0; i < 12; i++) begin
            chk("midrst_no_sep", 32'(dv[0]), 32'd0);
            @(negedge clk);
        end

        run_line(2, 32'h0000007F, 1'b0, 32'h0, -1, 0, 1'b0, -1, w8);
        run_line(2, 32'h000000A0, 1'b0, 32'h0, 1, 3, 1'b0, -1, w8);

        for (int i = 0; i < 12; i++) begin
            run_line(int'($urandom_range(0, 2)), $urandom, 1'b0, 32'h0, -1, 0, 1'b1, -1, w8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_hex_tx.md
# uart_hex_tx

Formats binary words as ASCII hexadecimal text and streams the characters, one byte per handshake, into the UART transmitter's `data_ready`/`data_valid`/`data_byte` byte port. It sits directly upstream of `uart_tx` and lets debug logic print register values over the serial link without a CPU. Each accepted word produces its digits most-significant nibble first, followed by a line separator.

## Interface

Parameters:
- `WIDTH`, default 32: bits per input word. Must be a multiple of 4 and at least 4. Digits per word: `NDIG = WIDTH/4`.
- `UPPER`, default 1: 1 selects `A`–`F` (0x41–0x46) for nibbles 10–15; 0 selects `a`–`f` (0x61–0x66).

Ports (one clock; reset is synchronous and active-high):
- `clk`, input, 1: system clock, same clock as `uart_tx`.
- `reset`, input, 1: synchronous, active-high reset.
- `word_ready`, output, 1: block can accept a word.
- `word_valid`, input, 1: upstream word available.
- `word_data`, input, `WIDTH`: word to print.
- `data_ready`, input, 1: from `uart_tx`; it accepts a byte.
- `data_valid`, output, 1: to `uart_tx`; `data_byte` is valid.
- `data_byte`, output, 8: ASCII character.

## Operation

- Handshake rule: a transfer occurs on a rising edge where both valid and ready are high. This applies on both the word side and the byte side.
- States:
  - `IDLE`: `word_ready`=1, `data_valid`=0. On a word transfer, capture `word_data` into a shift register, load digit counter with `NDIG-1`, present the first digit, go to `DIGIT`.
  - `DIGIT`: present the ASCII of the top nibble of the shift register.
    - On a byte transfer with counter ≠ 0: shift the register left 4 bits, decrement the counter, present the next digit.
    - On a byte transfer with counter = 0: go to `SEP`.
  - `SEP`: present the first separator byte (see Configuration).
    - On transfer with CRLF enabled: go to `LF`.
    - On transfer without CRLF: go to `IDLE`.
  - `LF`: present 0x0A. On transfer: go to `IDLE`.
- Nibble encoding: 0–9 map to 0x30–0x39; 10–15 map per `UPPER`.
- Backpressure: while `data_valid`=1 and `data_ready`=0, `data_byte` and `data_valid` hold stable. `data_valid` never drops without a transfer, except on reset.
- `word_ready` is 0 in every state except `IDLE`. A word presented mid-line waits; it is not lost.
- All outputs are registered.
- Reset values (asserted on any cycle, including mid-line): state `IDLE`, `word_ready`=0 while reset is high, `data_valid`=0, `data_byte`=0x00.
  - The partially printed word is discarded; no separator is sent.
  - `word_ready` rises on the first cycle after reset deasserts.

## Timing

- Word transfer at edge N: `data_valid`=1 with the first digit from N+1.
- Byte transfer at edge K (not the last byte of a line): the next character is on `data_byte` from K+1, and `data_valid` stays high. This gives back-to-back bytes with zero bubble.
- Last byte of a line transferred at edge K: `data_valid`=0 and `word_ready`=1 from K+1. The earliest next word transfer is K+1, and its first digit appears at K+2.
- Minimum cycles per word with `data_ready` tied high: `NDIG + S + 1`, where `S` is the separator length (2 or 1).

## Configuration

- Macro `UART_HEX_TX_CRLF_EN`:
  - Defined: the separator is two bytes, 0x0D (CR) then 0x0A (LF). The `LF` state is present.
  - Undefined: the separator is one byte, 0x20 (space). The `LF` state and its logic are compiled out, and `SEP` returns directly to `IDLE`.
- Default build defines `UART_HEX_TX_CRLF_EN`.

## Test plan

- `WIDTH`=32, `UPPER`=1, macro defined, `data_ready`=1; send 0xDEADBEEF.
  - Bytes: 0x44 0x45 0x41 0x44 0x42 0x45 0x45 0x46 0x0D 0x0A on consecutive cycles.
  - `word_ready` returns one cycle after 0x0A.
- `UPPER`=0; send 0x00C0FFEE.
  - Bytes: "00c0ffee" (0x30 0x30 0x63 0x30 0x66 0x66 0x65 0x65) then CR LF.
- Backpressure: send 0x12345678. Drop `data_ready` for 5 cycles while 0x33 ('3') is presented.
  - `data_byte` holds 0x33 and `data_valid` stays 1 throughout.
  - No digit is skipped or duplicated.
- Back-to-back: hold `word_valid`=1 with 0x00000001 then 0xFFFFFFFF.
  - Second word is accepted exactly one cycle after the first line's LF transfer.
  - Output is "00000001\r\nFFFFFFFF\r\n".
- Reset mid-line: assert `reset` for 1 cycle after the 3rd digit transfer of 0xA5A5A5A5.
  - Next cycle: `data_valid`=0, `data_byte`=0x00, `word_ready`=0.
  - `word_ready`=1 the cycle after; no CR/LF is emitted.
- Macro undefined, `WIDTH`=8; send 0x7F.
  - Bytes: 0x37 0x46 0x20, then `IDLE`.
